// File: rtl/stage_if_prefetch_if.sv
// Fetch-stage bundle: instruction-memory request/ack plus the decode-side instruction stream.
// Latency: none, wires only.
// Backpressure: decode stalls through i_Stall; memory wait states through a held i_PgmAck=0.
interface stage_if_prefetch_if #(
    parameter int DATA_IBUS_WIDTH = 32,
    parameter int ADDR_IBUS_WIDTH = 32
);
    // Instruction memory side
    logic [ADDR_IBUS_WIDTH-1:0] o_PgmAddr;
    logic                       o_PgmReq;
    logic                       i_PgmAck;
    logic [DATA_IBUS_WIDTH-1:0] i_PgmInst;

    // Redirect from a later stage
    logic                       i_PCSrc;
    logic [ADDR_IBUS_WIDTH-1:0] i_PCBranch;

    // Decode side
    logic                       i_Stall;
    logic                       o_Valid;
    logic [DATA_IBUS_WIDTH-1:0] o_Inst;
    logic [ADDR_IBUS_WIDTH-1:0] o_PC;
    logic [ADDR_IBUS_WIDTH-1:0] o_PCPlus4;
    logic                       o_Fault;

    // The prefetch stage itself
    modport master (
        output o_PgmAddr, o_PgmReq, o_Valid, o_Inst, o_PC, o_PCPlus4, o_Fault,
        input  i_PgmAck, i_PgmInst, i_PCSrc, i_PCBranch, i_Stall
    );

    // Memory, redirect source and decode stage
    modport slave (
        input  o_PgmAddr, o_PgmReq, o_Valid, o_Inst, o_PC, o_PCPlus4, o_Fault,
        output i_PgmAck, i_PgmInst, i_PCSrc, i_PCBranch, i_Stall
    );
endinterface

// File: rtl/stage_if_prefetch.sv
// Instruction prefetch: fetches sequentially into a FIFO_DEPTH-entry buffer, redirects on i_PCSrc.
// Latency: ack in cycle N -> o_Valid in N+1; redirect in N with zero-wait ack -> target shown in N+2.
// Backpressure: i_Stall holds the buffer head; fetching pauses (IDLE) while the buffer is full.
// Optional: define STAGE_IF_MISALIGN_CHECK_EN to fault on misaligned redirect targets.
module stage_if_prefetch #(
    parameter int                         DATA_IBUS_WIDTH = 32,
    parameter int                         ADDR_IBUS_WIDTH = 32,
    parameter int                         FIFO_DEPTH      = 4,
    parameter logic [ADDR_IBUS_WIDTH-1:0] RESET_ADDR      = '0
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    stage_if_prefetch_if.master pf_io
);

    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_IBUS_WIDTH-1:0] WORD_INC   = ADDR_IBUS_WIDTH'(4);
    localparam logic [ADDR_IBUS_WIDTH-1:0] ALIGN_MASK = ~(ADDR_IBUS_WIDTH'(3));

    // REQ: request live, result kept. DRAIN: request live, result thrown away.
`ifdef STAGE_IF_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_FAULT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;
`endif

    state_t                      state_q, state_d;
    logic [ADDR_IBUS_WIDTH-1:0]  fpc_q, fpc_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
`ifdef STAGE_IF_MISALIGN_CHECK_EN
    logic                        fault_q, fault_d;
    logic                        misalign;
`endif

    // Buffer storage carries no reset; only count/pointers qualify it.
    logic [DATA_IBUS_WIDTH-1:0]  inst_mem [FIFO_DEPTH];
    logic [ADDR_IBUS_WIDTH-1:0]  pc_mem   [FIFO_DEPTH];

    logic                        req_live;
    logic                        have_entry;
    logic                        full;
    logic                        push;
    logic                        pop;
    logic [CNT_W-1:0]            count_nxt;
    logic [ADDR_IBUS_WIDTH-1:0]  target;

    assign req_live   = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign have_entry = (count_q != '0);
    assign full       = (count_q == DEPTH_C);

    // A redirect kills both the word arriving this cycle and the head-of-buffer pop.
    assign push = (state_q == S_REQ) && pf_io.i_PgmAck && !pf_io.i_PCSrc && !full;
    assign pop  = have_entry && !pf_io.i_Stall && !pf_io.i_PCSrc;

    assign count_nxt = count_q
                     + {{(CNT_W-1){1'b0}}, push}
                     - {{(CNT_W-1){1'b0}}, pop};

    // Low address bits are ignored unless the misalignment check is built in.
    assign target = pf_io.i_PCBranch & ALIGN_MASK;
`ifdef STAGE_IF_MISALIGN_CHECK_EN
    assign misalign = (pf_io.i_PCBranch[1:0] != 2'b00);
`endif

    // Next-state logic: redirect first, then the per-state fetch sequencing.
    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        count_d  = count_nxt;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
`ifdef STAGE_IF_MISALIGN_CHECK_EN
        fault_d  = fault_q;
`endif

        if (pf_io.i_PCSrc) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
`ifdef STAGE_IF_MISALIGN_CHECK_EN
            if (misalign) begin
                // No fetch to a bad target; an outstanding request still has to finish.
                fault_d = 1'b1;
                state_d = (req_live && !pf_io.i_PgmAck) ? S_DRAIN : S_FAULT;
            end else begin
                fault_d = 1'b0;
                fpc_d   = target;
                state_d = (req_live && !pf_io.i_PgmAck) ? S_DRAIN : S_REQ;
            end
`else
            fpc_d   = target;
            state_d = (req_live && !pf_io.i_PgmAck) ? S_DRAIN : S_REQ;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q < DEPTH_C) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (push) begin
                        fpc_d   = fpc_q + WORD_INC;
                        state_d = (count_nxt < DEPTH_C) ? S_REQ : S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (pf_io.i_PgmAck) begin
`ifdef STAGE_IF_MISALIGN_CHECK_EN
                        state_d = fault_q ? S_FAULT : S_REQ;
`else
                        state_d = S_REQ;
`endif
                    end
                end
`ifdef STAGE_IF_MISALIGN_CHECK_EN
                S_FAULT: begin
                    state_d = S_FAULT;
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Control state registers; reset abandons any outstanding request.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= S_REQ;
            fpc_q    <= RESET_ADDR;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
`ifdef STAGE_IF_MISALIGN_CHECK_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
`ifdef STAGE_IF_MISALIGN_CHECK_EN
            fault_q  <= fault_d;
`endif
        end
    end

    // Buffer write: instruction word tagged with the address it was fetched from.
    always_ff @(posedge i_Clock) begin
        if (push && !i_Reset) begin
            inst_mem[wr_ptr_q] <= pf_io.i_PgmInst;
            pc_mem[wr_ptr_q]   <= fpc_q;
        end
    end

    // Reset masks the request and valid flags combinationally so nothing escapes the reset cycle.
    assign pf_io.o_PgmReq  = !i_Reset && req_live;
    assign pf_io.o_PgmAddr = fpc_q;
    assign pf_io.o_Valid   = !i_Reset && have_entry;
    assign pf_io.o_Inst    = inst_mem[rd_ptr_q];
    assign pf_io.o_PC      = pc_mem[rd_ptr_q];
    assign pf_io.o_PCPlus4 = pc_mem[rd_ptr_q] + WORD_INC;
`ifdef STAGE_IF_MISALIGN_CHECK_EN
    assign pf_io.o_Fault   = !i_Reset && fault_q;
`else
    assign pf_io.o_Fault   = 1'b0;
`endif

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Bench for stage_if_prefetch: table-driven fill/stall sequence, scoreboard-checked random stream,
// and hand-written redirect, wrap, misalignment and reset corner cases.
module tb_stage_if_prefetch;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    stage_if_prefetch_if #(.DATA_IBUS_WIDTH(32), .ADDR_IBUS_WIDTH(32)) bus ();

    stage_if_prefetch #(
        .DATA_IBUS_WIDTH(32),
        .ADDR_IBUS_WIDTH(32),
        .FIFO_DEPTH(4),
        .RESET_ADDR(32'h0)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .pf_io(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word content is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h0F0F_3C00;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle: inputs applied just after the falling edge, outputs examined 1 time unit later.
    task automatic drive(input logic r, input logic ack, input logic stall, input logic pcsrc,
                         input logic [31:0] br, input logic use_inst, input logic [31:0] inst);
        @(negedge clk);
        rst            = r;
        bus.i_PgmAck   = ack;
        bus.i_Stall    = stall;
        bus.i_PCSrc    = pcsrc;
        bus.i_PCBranch = br;
        bus.i_PgmInst  = use_inst ? inst : mem_word(bus.o_PgmAddr);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        ack;
        logic        stall;
        logic        chk_addr;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic a, input logic s, input logic ca,
                                input logic rq, input logic [31:0] ad, input logic v,
                                input logic [31:0] pc);
        vec_t t;
        t.rst = r; t.ack = a; t.stall = s; t.chk_addr = ca;
        t.exp_req = rq; t.exp_addr = ad; t.exp_valid = v; t.exp_pc = pc;
        return t;
    endfunction

    vec_t        tbl [17];
    logic [31:0] sb_q [$];
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    int          popped;

    initial begin
        rst            = 1'b1;
        bus.i_PgmAck   = 1'b0;
        bus.i_PgmInst  = '0;
        bus.i_PCSrc    = 1'b0;
        bus.i_PCBranch = '0;
        bus.i_Stall    = 1'b1;

        // Reset, fill to 4 with decode stalled, single pop, refill, drain.
        //            rst ack stl ca  req addr   vld pc
        tbl[0]  = mk(1,  0,  1,  0,  0,  32'd0,  0,  32'd0);
        tbl[1]  = mk(1,  0,  1,  1,  0,  32'd0,  0,  32'd0);
        tbl[2]  = mk(0,  1,  1,  1,  1,  32'd0,  0,  32'd0);
        tbl[3]  = mk(0,  1,  1,  1,  1,  32'd4,  1,  32'd0);
        tbl[4]  = mk(0,  1,  1,  1,  1,  32'd8,  1,  32'd0);
        tbl[5]  = mk(0,  1,  1,  1,  1,  32'd12, 1,  32'd0);
        tbl[6]  = mk(0,  1,  1,  1,  0,  32'd16, 1,  32'd0);
        tbl[7]  = mk(0,  0,  1,  1,  0,  32'd16, 1,  32'd0);
        tbl[8]  = mk(0,  0,  0,  1,  0,  32'd16, 1,  32'd0);
        tbl[9]  = mk(0,  0,  1,  1,  0,  32'd16, 1,  32'd4);
        tbl[10] = mk(0,  0,  1,  1,  1,  32'd16, 1,  32'd4);
        tbl[11] = mk(0,  1,  1,  1,  1,  32'd16, 1,  32'd4);
        tbl[12] = mk(0,  0,  0,  1,  0,  32'd20, 1,  32'd4);
        tbl[13] = mk(0,  0,  0,  1,  0,  32'd20, 1,  32'd8);
        tbl[14] = mk(0,  0,  0,  1,  1,  32'd20, 1,  32'd12);
        tbl[15] = mk(0,  0,  0,  1,  1,  32'd20, 1,  32'd16);
        tbl[16] = mk(0,  0,  0,  1,  1,  32'd20, 0,  32'd0);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst, tbl[i].ack, tbl[i].stall, 1'b0, 32'h0, 1'b0, 32'h0);
            chk($sformatf("tbl%0d req", i), 64'(bus.o_PgmReq), 64'(tbl[i].exp_req));
            chk($sformatf("tbl%0d valid", i), 64'(bus.o_Valid), 64'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d fault", i), 64'(bus.o_Fault), 64'(1'b0));
            if (tbl[i].chk_addr)
                chk($sformatf("tbl%0d addr", i), 64'(bus.o_PgmAddr), 64'(tbl[i].exp_addr));
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d pc", i), 64'(bus.o_PC), 64'(tbl[i].exp_pc));
                chk($sformatf("tbl%0d inst", i), 64'(bus.o_Inst), 64'(mem_word(tbl[i].exp_pc)));
                chk($sformatf("tbl%0d pc4", i), 64'(bus.o_PCPlus4), 64'(tbl[i].exp_pc + 32'd4));
            end
        end

        // Random wait states and stalls, no redirects: strictly sequential stream.
        drive(1, 0, 0, 0, 32'h0, 1'b0, 32'h0);
        drive(1, 0, 0, 0, 32'h0, 1'b0, 32'h0);
        exp_fetch = 32'h0;
        popped    = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst         = 1'b0;
            bus.i_PCSrc = 1'b0;
            bus.i_Stall = (c >= 380) ? 1'b0 : ($urandom_range(0, 2) == 0);
            chk("sb valid", 64'(bus.o_Valid), 64'(sb_q.size() != 0));
            if (bus.o_Valid && !bus.i_Stall && sb_q.size() != 0) begin
                exp_pc = sb_q.pop_front();
                chk("sb pc", 64'(bus.o_PC), 64'(exp_pc));
                chk("sb inst", 64'(bus.o_Inst), 64'(mem_word(exp_pc)));
                popped++;
            end
            if (bus.o_PgmReq && c < 370 && ($urandom_range(0, 1) == 1)) begin
                chk("sb fetch addr", 64'(bus.o_PgmAddr), 64'(exp_fetch));
                bus.i_PgmAck  = 1'b1;
                bus.i_PgmInst = mem_word(bus.o_PgmAddr);
                sb_q.push_back(exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end else begin
                bus.i_PgmAck  = 1'b0;
                bus.i_PgmInst = 32'hDEAD_BEEF;
            end
        end
        chk("sb drained", 64'(sb_q.size()), 64'(0));
        chk("sb progress", 64'(popped > 40), 64'(1));

        // Delayed ack with redirect: stale word from 0x10 must never appear.
        drive(1, 0, 0, 0, 32'h0, 1'b0, 32'h0);
        drive(1, 0, 0, 0, 32'h0, 1'b0, 32'h0);
        drive(0, 1, 0, 0, 32'h0, 1'b0, 32'h0);
        chk("post-reset req", 64'(bus.o_PgmReq), 64'(1));
        chk("post-reset addr", 64'(bus.o_PgmAddr), 64'(32'h0));
        for (int k = 0; k < 3; k++) drive(0, 1, 0, 0, 32'h0, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 1'b0, 32'h0);
        chk("pending addr", 64'(bus.o_PgmAddr), 64'(32'h10));
        drive(0, 0, 0, 1, 32'h100, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 1'b0, 32'h0);
        chk("drain req", 64'(bus.o_PgmReq), 64'(1));
        chk("drain addr", 64'(bus.o_PgmAddr), 64'(32'h100));
        chk("drain valid", 64'(bus.o_Valid), 64'(0));
        drive(0, 1, 0, 0, 32'h0, 1'b1, mem_word(32'h10));
        drive(0, 1, 0, 0, 32'h0, 1'b0, 32'h0);
        chk("refetch addr", 64'(bus.o_PgmAddr), 64'(32'h100));
        chk("stale dropped", 64'(bus.o_Valid), 64'(0));
        drive(0, 0, 1, 0, 32'h0, 1'b0, 32'h0);
        chk("target valid", 64'(bus.o_Valid), 64'(1));
        chk("target pc", 64'(bus.o_PC), 64'(32'h100));
        chk("target inst", 64'(bus.o_Inst), 64'(mem_word(32'h100)));

        // Redirect to top-of-memory with simultaneous ack and stall; then address wrap.
        drive(0, 1, 1, 1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        drive(0, 1, 1, 0, 32'h0, 1'b0, 32'h0);
        chk("flush valid", 64'(bus.o_Valid), 64'(0));
        chk("wrap fetch", 64'(bus.o_PgmAddr), 64'(32'hFFFF_FFFC));
        drive(0, 0, 1, 0, 32'h0, 1'b0, 32'h0);
        chk("wrap pc", 64'(bus.o_PC), 64'(32'hFFFF_FFFC));
        chk("wrap pc4", 64'(bus.o_PCPlus4), 64'(32'h0));
        chk("wrap next addr", 64'(bus.o_PgmAddr), 64'(32'h0));

        // Redirect to 0x200 with ack and stall: empty next cycle, target two cycles later.
        drive(0, 1, 1, 1, 32'h200, 1'b0, 32'h0);
        drive(0, 1, 1, 0, 32'h0, 1'b0, 32'h0);
        chk("r200 valid0", 64'(bus.o_Valid), 64'(0));
        chk("r200 addr", 64'(bus.o_PgmAddr), 64'(32'h200));
        drive(0, 0, 0, 0, 32'h0, 1'b0, 32'h0);
        chk("r200 pc", 64'(bus.o_PC), 64'(32'h200));
        chk("r200 valid1", 64'(bus.o_Valid), 64'(1));

        // Misaligned redirect (ack of the live request dropped), then aligned redirect.
        drive(0, 1, 0, 1, 32'h102, 1'b0, 32'h0);
        drive(0, 0, 0, 1, 32'h104, 1'b0, 32'h0);
`ifdef STAGE_IF_MISALIGN_CHECK_EN
        chk("misalign fault", 64'(bus.o_Fault), 64'(1));
        chk("misalign no req", 64'(bus.o_PgmReq), 64'(0));
`else
        chk("misalign fault", 64'(bus.o_Fault), 64'(0));
        chk("misalign req", 64'(bus.o_PgmReq), 64'(1));
        chk("misalign masked", 64'(bus.o_PgmAddr), 64'(32'h100));
`endif
        drive(0, 0, 0, 0, 32'h0, 1'b0, 32'h0);
        chk("aligned fault", 64'(bus.o_Fault), 64'(0));
        chk("aligned req", 64'(bus.o_PgmReq), 64'(1));
        chk("aligned addr", 64'(bus.o_PgmAddr), 64'(32'h104));

        // Reset mid-request with an ack during reset.
        drive(1, 1, 0, 0, 32'h0, 1'b0, 32'h0);
        chk("rst req", 64'(bus.o_PgmReq), 64'(0));
        chk("rst valid", 64'(bus.o_Valid), 64'(0));
        chk("rst fault", 64'(bus.o_Fault), 64'(0));
        drive(0, 0, 0, 0, 32'h0, 1'b0, 32'h0);
        chk("rst exit req", 64'(bus.o_PgmReq), 64'(1));
        chk("rst exit addr", 64'(bus.o_PgmAddr), 64'(32'h0));
        drive(0, 0, 0, 0, 32'h0, 1'b0, 32'h0);
        chk("rst ack ignored", 64'(bus.o_Valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
